// File: rtl/ase_pkg.sv
// rtl/ase_pkg.sv - ASE TX/RX header types and the expected-response helper.
package ase_pkg;

  localparam int ASE_TID_WIDTH = 6;

  typedef enum logic [3:0] {
    ASE_WRLINE_I = 4'h0,
    ASE_WRLINE_M = 4'h1,
    ASE_WRPUSH_I = 4'h2,
    ASE_WRFENCE  = 4'h4,
    ASE_INTR     = 4'h6,
    ASE_RDLINE_I = 4'h8,
    ASE_RDLINE_S = 4'h9
  } ase_reqtype_t;

  typedef struct packed {
    ase_reqtype_t reqtype;
    logic [1:0]   len;
    logic [25:0]  addr;
    logic [15:0]  mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [3:0]  resptype;
    logic [1:0]  cl_num;
    logic [15:0] mdata;
  } RxHdr_t;

  // Returns expected response count minus one: reads answer once per line.
  function automatic logic [1:0] ase_exp_rsp(TxHdr_t hdr);
    if (hdr.reqtype == ASE_RDLINE_I || hdr.reqtype == ASE_RDLINE_S)
      return hdr.len;
    return 2'd0;
  endfunction

endpackage

// File: rtl/ase_rr_arbiter.sv
// rtl/ase_rr_arbiter.sv - round-robin arbiter with internal pointer.
module ase_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;
  logic [IW:0]   nxt;
  logic          found;

  // Scan from ptr upward with explicit wrap so N need not be a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IW-1:0]]    = 1'b1;
        gnt_idx              = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gnt_idx} + (IW+1)'(1);
    if (nxt >= (IW+1)'(N)) nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (advance) ptr <= nxt[IW-1:0];
  end

endmodule

// File: rtl/ase_tx_tid_scheduler.sv
// rtl/ase_tx_tid_scheduler.sv - shares the TX channel among requesters and tags
// each request with a TID from a free pool, retiring it when all responses return.
module ase_tx_tid_scheduler
  import ase_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int TID_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  TxHdr_t [NUM_REQ-1:0]       req_hdr,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_almfull,
  output logic                       tx_valid,
  output TxHdr_t                     tx_hdr,
  output logic [TID_WIDTH-1:0]       tx_tid,
  output logic [$clog2(NUM_REQ)-1:0] tx_src,
  input  logic                       rsp_valid,
  input  RxHdr_t                     rsp_hdr,
  input  logic [TID_WIDTH-1:0]       rsp_tid,
  output logic [TID_WIDTH:0]         outstanding_cnt,
  output logic                       err_unknown_tid
);

  localparam int SW = $clog2(NUM_REQ);

  logic [MAX_OUTSTANDING-1:0] busy;
  logic [1:0]                 exp_cnt [MAX_OUTSTANDING];
  logic [TID_WIDTH-1:0]       free_tid;
  logic                       pool_avail;
  logic [NUM_REQ-1:0]         eligible;
  logic [NUM_REQ-1:0]         arb_req;
  logic [NUM_REQ-1:0]         gnt;
  logic [SW-1:0]              gnt_idx;
  TxHdr_t                     sel_hdr;
  logic                       accept;
  logic                       alloc;
  logic                       rsp_hit;
  logic                       rsp_done;
  logic                       unused_rsp_hdr;

  assign unused_rsp_hdr = ^rsp_hdr;

  always_comb begin
    free_tid = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
      if (!busy[i]) free_tid = TID_WIDTH'(i);
  end

  assign pool_avail = ~&busy;

  // Fences never take a TID, so they stay grantable with a full pool.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NUM_REQ; r++)
      eligible[r] = req_valid[r] & ~tx_almfull &
                    (pool_avail | (req_hdr[r].reqtype == ASE_WRFENCE));
  end

  assign arb_req = eligible & {NUM_REQ{rst_n}};

  ase_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign sel_hdr   = req_hdr[gnt_idx];
  assign alloc     = accept && (sel_hdr.reqtype != ASE_WRFENCE);
  assign rsp_hit   = rsp_valid && busy[rsp_tid];
  assign rsp_done  = rsp_hit && (exp_cnt[rsp_tid] == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= '0;
      outstanding_cnt <= '0;
      tx_valid        <= 1'b0;
      tx_hdr          <= '0;
      tx_tid          <= '0;
      tx_src          <= '0;
      err_unknown_tid <= 1'b0;
    end else begin
      if (alloc)    busy[free_tid] <= 1'b1;
      if (rsp_done) busy[rsp_tid]  <= 1'b0;
      if (alloc && !rsp_done)      outstanding_cnt <= outstanding_cnt + 1'b1;
      else if (!alloc && rsp_done) outstanding_cnt <= outstanding_cnt - 1'b1;
      tx_valid <= accept;
      if (accept) begin
        tx_hdr <= sel_hdr;
        tx_tid <= alloc ? free_tid : '0;
        tx_src <= gnt_idx;
      end
      err_unknown_tid <= rsp_valid && !busy[rsp_tid];
    end
  end

  // Count RAM needs no reset: entries are only read while their busy bit is set.
  always_ff @(posedge clk) begin
    if (alloc) exp_cnt[free_tid] <= ase_exp_rsp(sel_hdr);
    if (rsp_hit && !rsp_done) exp_cnt[rsp_tid] <= exp_cnt[rsp_tid] - 2'd1;
  end

endmodule
